// File: rtl/nibble_serial_adder_ctrl_if.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if: operand/result bus plus shared 4-bit adder link
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  // Operand source side
  logic                   start;
  logic                   sub;
  logic [4*NIBBLES-1:0]   op_a;
  logic [4*NIBBLES-1:0]   op_b;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   result;
  logic                   cout;
  logic                   ovf;

  // External 4-bit adder side
  logic [3:0]             add_a;
  logic [3:0]             add_b;
  logic                   add_ci;
  logic [3:0]             add_s;
  logic                   add_co;

  modport slave (
    input  start, sub, op_a, op_b, add_s, add_co,
    output busy, done, result, cout, ovf, add_a, add_b, add_ci
  );

  modport master (
    output start, sub, op_a, op_b, add_s, add_co,
    input  busy, done, result, cout, ovf, add_a, add_b, add_ci
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl: LSB-first add/sub sequencer over a shared 4-bit adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int c_WIDTH = 4 * NIBBLES;
  localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [c_WIDTH-1:0]    r_a;
  logic [c_WIDTH-1:0]    r_b;
  logic                  r_sub;
  logic [c_IDX_W-1:0]    r_idx;
  logic                  r_carry;
  logic [c_WIDTH-1:0]    r_result;
  logic                  r_cout;
  logic                  r_ovf;

  logic [3:0]            w_a_cur;
  logic [3:0]            w_b_cur;
  logic [c_WIDTH-1:0]    w_result_nxt;
  logic                  w_last;
  logic                  w_ovf;

  // Select the active nibble and merge the adder sum into its result slot.
  always_comb begin
    w_a_cur      = '0;
    w_b_cur      = '0;
    w_result_nxt = r_result;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_a_cur                 = r_a[4*k +: 4];
        w_b_cur                 = r_b[4*k +: 4];
        w_result_nxt[4*k +: 4]  = bus.add_s;
      end
    end
  end

  assign w_last = (r_idx == c_IDX_W'(NIBBLES - 1));

  // Sum MSB comes straight from the adder on the final slice.
  assign w_ovf = (r_a[c_WIDTH-1] == (r_b[c_WIDTH-1] ^ r_sub)) &&
                 (bus.add_s[3] != r_a[c_WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_ci  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy   = 1'b1;
        bus.add_a  = w_a_cur;
        bus.add_b  = w_b_cur ^ {4{r_sub}};
        bus.add_ci = r_carry;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_sub   <= bus.sub;
            r_idx   <= '0;
            // Two's complement subtract: inverted B plus an initial carry of one.
            r_carry <= bus.sub;
          end
        end
        S_RUN: begin
          r_result <= w_result_nxt;
          r_carry  <= bus.add_co;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= bus.add_co;
            r_ovf  <= w_ovf;
          end else begin
            r_idx  <= r_idx + c_IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl: directed self-checking bench with 4-bit adder model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [3:0] ci_log;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference 4-bit ripple-carry adder
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs after accept, wait for done (bounded),
  // check results, then step into the following idle cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] exp_res,
                        input logic exp_cout, input logic exp_ovf);
    int n;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = ~b;
    bus.sub   = ~s;
    ci_log    = 4'b0000;
    n = 0;
    while (!bus.done && n < 20) begin
      if (n < 4) ci_log[n] = bus.add_ci;
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    check({tag, "_add_a_in_done"}, 32'(bus.add_a), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int dcount;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #1 rst = 1'b1;
    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_add", 32'({bus.add_a, bus.add_b, bus.add_ci}), 32'd0);
    rst = 1'b0;
    step();

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("add_wrap_ci_seq", 32'(ci_log), 32'hE);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check("sub_neg_ci_seq", 32'(ci_log), 32'h1);

    // Start held high through RUN and DONE with different operands.
    bus.op_a  = 16'h0011;
    bus.op_b  = 16'h0022;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h1111;
    bus.sub   = 1'b1;
    dcount    = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        dcount++;
        check("ignore_result", 32'(bus.result), 32'h0033);
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    check("ignore_done_count", 32'(dcount), 32'd1);
    check("ignore_result_held", 32'(bus.result), 32'h0033);

    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    // Issued in the cycle right after the previous done.
    run_op("b2b", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Make cout/ovf non-zero before the abort so the reset is observable.
    run_op("pre_abort", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    bus.op_a  = 16'h1234;
    bus.op_b  = 16'h0FFF;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    check("abort_at_k2_add_a", 32'(bus.add_a), 32'h2);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
    check("abort_add", 32'({bus.add_a, bus.add_b, bus.add_ci}), 32'd0);
    step();
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) dcount++;
      step();
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    run_op("post_abort", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
